// File: rtl/tb_sequencer_pkg.sv
// Shared types and helpers for the testcase sequencer.
//   state_e   : sequencer FSM states
//   C_SEL_ALL : GC_TESTCASE value that selects "run every testcase"
//   sat_inc   : saturating increment for counters up to C_CNT_MAX_W bits
package tb_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RECORD,
    NEXT,
    FINISH
  } state_e;

  localparam int unsigned C_SEL_ALL   = 0;
  localparam int unsigned C_CNT_MAX_W = 32;

  // Increment, holding at the all-ones value of a 'width'-bit counter.
  function automatic logic [C_CNT_MAX_W-1:0] sat_inc(input logic [C_CNT_MAX_W-1:0] value,
                                                     input int unsigned             width);
    logic [C_CNT_MAX_W-1:0] limit;
    limit = {C_CNT_MAX_W{1'b1}} >> (C_CNT_MAX_W - width);
    return (value >= limit) ? value : value + C_CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/tb_sequencer_watchdog.sv
// Per-testcase watchdog.
//   clk, arst_n : clock, asynchronous active-low reset
//   load        : restart the count (testcase launch)
//   en          : count one cycle (testcase in flight)
//   expired     : high during the GC_TIMEOUT_CYCLES-th enabled cycle after load and later
module tb_sequencer_watchdog #(
  parameter int unsigned GC_TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic arst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (GC_TIMEOUT_CYCLES > 1) ? $clog2(GC_TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  // cnt_q holds enabled cycles already seen; expired is registered one step ahead
  // so it is valid during the cycle in which the budget runs out.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt_q   <= '0;
      expired <= (GC_TIMEOUT_CYCLES <= 1);
    end else if (en && !expired) begin
      cnt_q   <= cnt_q + CW'(1);
      expired <= ((cnt_q + CW'(1)) == CW'(GC_TIMEOUT_CYCLES - 1));
    end
  end

endmodule

// File: rtl/tb_testcase_sequencer.sv
// Testcase sequencer: runs one selected testcase or all of them in order,
// each under a watchdog, and accumulates pass/fail/timeout counts.
//   run_i, abort_i          : start a run / terminate the current run
//   tc_start_o, tc_id_o     : launch pulse and ID of the current testcase (0 when idle)
//   tc_done_i, tc_pass_i    : completion strobe and verdict from the testcase
//   busy_o, done_o          : run in progress / end-of-run pulse
//   all_pass_o              : run verdict, valid from done_o until the next run_i
//   pass/fail/timeout_cnt_o : saturating counters for the current run
module tb_testcase_sequencer
  import tb_sequencer_pkg::*;
#(
  parameter int unsigned GC_NUM_TESTCASES  = 4,
  parameter int unsigned GC_TESTCASE       = 0,
  parameter int unsigned GC_TIMEOUT_CYCLES = 1000,
  parameter int unsigned GC_ID_WIDTH       = 8,
  parameter int unsigned GC_CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    run_i,
  input  logic                    abort_i,
  output logic                    tc_start_o,
  output logic [GC_ID_WIDTH-1:0]  tc_id_o,
  input  logic                    tc_done_i,
  input  logic                    tc_pass_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    all_pass_o,
  output logic [GC_CNT_WIDTH-1:0] pass_cnt_o,
  output logic [GC_CNT_WIDTH-1:0] fail_cnt_o,
  output logic [GC_CNT_WIDTH-1:0] timeout_cnt_o
);

  localparam logic                   C_SINGLE   = (GC_TESTCASE != C_SEL_ALL);
  localparam logic                   C_ILLEGAL  = (GC_TESTCASE > GC_NUM_TESTCASES);
  localparam logic [GC_ID_WIDTH-1:0] C_FIRST_ID =
    GC_ID_WIDTH'((GC_TESTCASE == C_SEL_ALL) ? 1 : GC_TESTCASE);
  localparam logic [GC_ID_WIDTH-1:0] C_LAST_ID  = GC_ID_WIDTH'(GC_NUM_TESTCASES);

  state_e                  state_q, state_d;
  logic                    verdict_q, verdict_d;
  logic [GC_ID_WIDTH-1:0]  id_d;
  logic [GC_CNT_WIDTH-1:0] pass_d, fail_d, tout_d;
  logic                    all_pass_d, start_d, busy_d, done_d;
  logic                    aborting;
  logic                    wd_expired;

  function automatic logic [GC_CNT_WIDTH-1:0] cnt_inc(input logic [GC_CNT_WIDTH-1:0] v);
    return GC_CNT_WIDTH'(sat_inc(C_CNT_MAX_W'(v), GC_CNT_WIDTH));
  endfunction

  tb_sequencer_watchdog #(
    .GC_TIMEOUT_CYCLES(GC_TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .arst_n (arst_n),
    .load   (state_q == LAUNCH),
    .en     (state_q == WAIT),
    .expired(wd_expired)
  );

  // Next-state and next-output logic; outputs are registered from the *_d values
  // so that each output lines up with the state it describes.
  always_comb begin
    state_d    = state_q;
    verdict_d  = verdict_q;
    id_d       = tc_id_o;
    pass_d     = pass_cnt_o;
    fail_d     = fail_cnt_o;
    tout_d     = timeout_cnt_o;
    all_pass_d = all_pass_o;
    aborting   = 1'b0;

    case (state_q)
      IDLE: begin
        if (run_i) begin
          pass_d     = '0;
          fail_d     = '0;
          tout_d     = '0;
          all_pass_d = 1'b0;
          if (C_ILLEGAL) begin
            fail_d  = GC_CNT_WIDTH'(1);
            state_d = FINISH;
          end else begin
            id_d    = C_FIRST_ID;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        // Completion takes priority over a simultaneous watchdog expiry.
        if (tc_done_i) begin
          verdict_d = tc_pass_i;
          state_d   = RECORD;
        end else if (wd_expired) begin
          fail_d  = cnt_inc(fail_cnt_o);
          tout_d  = cnt_inc(timeout_cnt_o);
          state_d = NEXT;
        end
      end
      RECORD: begin
        if (verdict_q) pass_d = cnt_inc(pass_cnt_o);
        else           fail_d = cnt_inc(fail_cnt_o);
        state_d = NEXT;
      end
      NEXT: begin
        if (C_SINGLE || (tc_id_o == C_LAST_ID)) begin
          state_d = FINISH;
        end else begin
          id_d    = tc_id_o + GC_ID_WIDTH'(1);
          state_d = LAUNCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort discards whatever the in-flight testcase would have contributed.
    if (abort_i && (state_q inside {LAUNCH, WAIT, RECORD, NEXT})) begin
      aborting = 1'b1;
      pass_d   = pass_cnt_o;
      fail_d   = fail_cnt_o;
      tout_d   = timeout_cnt_o;
      state_d  = FINISH;
    end

    if (state_d == FINISH) begin
      id_d       = '0;
      all_pass_d = !aborting && (fail_d == '0) && (pass_d != '0);
    end

    start_d = (state_d == LAUNCH);
    busy_d  = (state_d inside {LAUNCH, WAIT, RECORD, NEXT});
    done_d  = (state_d == FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      verdict_q     <= 1'b0;
      tc_id_o       <= '0;
      tc_start_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      all_pass_o    <= 1'b0;
      pass_cnt_o    <= '0;
      fail_cnt_o    <= '0;
      timeout_cnt_o <= '0;
    end else begin
      state_q       <= state_d;
      verdict_q     <= verdict_d;
      tc_id_o       <= id_d;
      tc_start_o    <= start_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      all_pass_o    <= all_pass_d;
      pass_cnt_o    <= pass_d;
      fail_cnt_o    <= fail_d;
      timeout_cnt_o <= tout_d;
    end
  end

endmodule

// File: tb/tb_tb_testcase_sequencer.sv
// Scoreboard bench for tb_testcase_sequencer.
// dut0: run-all, N=4, 10-cycle watchdog; dut1: single testcase 3; dut2: illegal selection 7.
module tb_tb_testcase_sequencer;

  localparam int NDUT    = 3;
  localparam int REF_DNE = 1;  // end-of-run latency measured from last tc_done_i
  localparam int REF_CTL = 2;  // end-of-run latency measured from run_i / abort_i

  typedef struct { int id; int p; int f; int t; } start_t;
  typedef struct { int p; int f; int t; int ap; int ref_sel; } res_t;

  logic        clk;
  logic        rst_n;
  logic        run     [NDUT];
  logic        abort   [NDUT];
  logic        done_in [NDUT];
  logic        pass_in [NDUT];
  logic        start   [NDUT];
  logic        busy    [NDUT];
  logic        done    [NDUT];
  logic        ap      [NDUT];
  logic [7:0]  id      [NDUT];
  logic [15:0] pc      [NDUT];
  logic [15:0] fc      [NDUT];
  logic [15:0] tc      [NDUT];

  start_t sq [NDUT][$];
  res_t   rq [NDUT][$];

  int lat_tab  [NDUT][8];
  bit pass_tab [NDUT][8];
  int last_done_cyc [NDUT];
  int last_ctl_cyc  [NDUT];
  int cyc;
  int vectors;
  int miscompares;

  tb_testcase_sequencer #(
    .GC_NUM_TESTCASES(4), .GC_TESTCASE(0), .GC_TIMEOUT_CYCLES(10)
  ) u_dut0 (
    .clk(clk), .arst_n(rst_n), .run_i(run[0]), .abort_i(abort[0]),
    .tc_start_o(start[0]), .tc_id_o(id[0]), .tc_done_i(done_in[0]), .tc_pass_i(pass_in[0]),
    .busy_o(busy[0]), .done_o(done[0]), .all_pass_o(ap[0]),
    .pass_cnt_o(pc[0]), .fail_cnt_o(fc[0]), .timeout_cnt_o(tc[0])
  );

  tb_testcase_sequencer #(
    .GC_NUM_TESTCASES(4), .GC_TESTCASE(3), .GC_TIMEOUT_CYCLES(10)
  ) u_dut1 (
    .clk(clk), .arst_n(rst_n), .run_i(run[1]), .abort_i(abort[1]),
    .tc_start_o(start[1]), .tc_id_o(id[1]), .tc_done_i(done_in[1]), .tc_pass_i(pass_in[1]),
    .busy_o(busy[1]), .done_o(done[1]), .all_pass_o(ap[1]),
    .pass_cnt_o(pc[1]), .fail_cnt_o(fc[1]), .timeout_cnt_o(tc[1])
  );

  tb_testcase_sequencer #(
    .GC_NUM_TESTCASES(4), .GC_TESTCASE(7), .GC_TIMEOUT_CYCLES(10)
  ) u_dut2 (
    .clk(clk), .arst_n(rst_n), .run_i(run[2]), .abort_i(abort[2]),
    .tc_start_o(start[2]), .tc_id_o(id[2]), .tc_done_i(done_in[2]), .tc_pass_i(pass_in[2]),
    .busy_o(busy[2]), .done_o(done[2]), .all_pass_o(ap[2]),
    .pass_cnt_o(pc[2]), .fail_cnt_o(fc[2]), .timeout_cnt_o(tc[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %s, expected none", name, what);
  endtask

  // Responder and monitor per DUT.
  for (genvar g = 0; g < NDUT; g++) begin : g_side
    initial begin : responder
      int cnt;
      int cur;
      cnt = 0;
      cur = 0;
      forever begin
        @(posedge clk);
        #1;
        done_in[g] = 1'b0;
        pass_in[g] = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            done_in[g]       = 1'b1;
            pass_in[g]       = pass_tab[g][cur];
            last_done_cyc[g] = cyc;
          end
        end
        if (start[g]) begin
          cur = int'(id[g][2:0]);
          cnt = lat_tab[g][cur];
        end
      end
    end

    initial begin : monitor
      start_t se;
      res_t   re;
      int     lat;
      forever begin
        @(negedge clk);
        if (start[g]) begin
          if (sq[g].size() == 0) begin
            flag_fail($sformatf("dut%0d start", g), $sformatf("unexpected start id %0d", id[g]));
          end else begin
            se = sq[g].pop_front();
            check($sformatf("dut%0d start id", g), int'(id[g]), se.id);
            check($sformatf("dut%0d id%0d pass_cnt", g, se.id), int'(pc[g]), se.p);
            check($sformatf("dut%0d id%0d fail_cnt", g, se.id), int'(fc[g]), se.f);
            check($sformatf("dut%0d id%0d timeout_cnt", g, se.id), int'(tc[g]), se.t);
            check($sformatf("dut%0d id%0d busy", g, se.id), int'(busy[g]), 1);
          end
        end
        if (done[g]) begin
          if (rq[g].size() == 0) begin
            flag_fail($sformatf("dut%0d done", g), "unexpected done_o");
          end else begin
            re = rq[g].pop_front();
            check($sformatf("dut%0d final pass_cnt", g), int'(pc[g]), re.p);
            check($sformatf("dut%0d final fail_cnt", g), int'(fc[g]), re.f);
            check($sformatf("dut%0d final timeout_cnt", g), int'(tc[g]), re.t);
            check($sformatf("dut%0d all_pass", g), int'(ap[g]), re.ap);
            check($sformatf("dut%0d final id", g), int'(id[g]), 0);
            check($sformatf("dut%0d final busy", g), int'(busy[g]), 0);
            if (re.ref_sel == REF_DNE) begin
              lat = cyc - last_done_cyc[g];
              check($sformatf("dut%0d tc_done->done_o latency", g), lat, 3);
            end else begin
              lat = cyc - last_ctl_cyc[g];
              check($sformatf("dut%0d run/abort->done_o latency", g), lat, 1);
            end
          end
        end
      end
    end
  end

  task automatic expect_start(input int g, input int i, input int p, input int f, input int t);
    start_t e;
    e = '{i, p, f, t};
    sq[g].push_back(e);
  endtask

  task automatic expect_result(input int g, input int p, input int f, input int t,
                               input int a, input int r);
    res_t e;
    e = '{p, f, t, a, r};
    rq[g].push_back(e);
  endtask

  task automatic set_tab(input int g, input int l1, input int l2, input int l3, input int l4,
                         input bit p1, input bit p2, input bit p3, input bit p4);
    lat_tab[g][1] = l1;  lat_tab[g][2] = l2;  lat_tab[g][3] = l3;  lat_tab[g][4] = l4;
    pass_tab[g][1] = p1; pass_tab[g][2] = p2; pass_tab[g][3] = p3; pass_tab[g][4] = p4;
  endtask

  task automatic pulse_run(input int g);
    @(posedge clk);
    #1;
    run[g] = 1'b1;
    last_ctl_cyc[g] = cyc;
    @(posedge clk);
    #1;
    run[g] = 1'b0;
  endtask

  task automatic pulse_abort(input int g);
    @(posedge clk);
    #1;
    abort[g] = 1'b1;
    last_ctl_cyc[g] = cyc;
    @(posedge clk);
    #1;
    abort[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (!(sq[g].size() == 0 && rq[g].size() == 0 && !busy[g]) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) flag_fail($sformatf("dut%0d run end", g), "cycle budget exhausted");
  endtask

  task automatic wait_tc(input int g, input int tcid);
    int n;
    n = 0;
    while (!(busy[g] && !start[g] && int'(id[g]) == tcid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) flag_fail($sformatf("dut%0d wait tc%0d", g, tcid), "cycle budget exhausted");
  endtask

  task automatic check_zero(input int g, input string tag);
    check($sformatf("%s dut%0d tc_start", tag, g), int'(start[g]), 0);
    check($sformatf("%s dut%0d tc_id", tag, g), int'(id[g]), 0);
    check($sformatf("%s dut%0d busy", tag, g), int'(busy[g]), 0);
    check($sformatf("%s dut%0d done", tag, g), int'(done[g]), 0);
    check($sformatf("%s dut%0d all_pass", tag, g), int'(ap[g]), 0);
    check($sformatf("%s dut%0d pass_cnt", tag, g), int'(pc[g]), 0);
    check($sformatf("%s dut%0d fail_cnt", tag, g), int'(fc[g]), 0);
    check($sformatf("%s dut%0d timeout_cnt", tag, g), int'(tc[g]), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      run[g] = 1'b0;
      abort[g] = 1'b0;
      last_done_cyc[g] = 0;
      last_ctl_cyc[g] = 0;
      for (int k = 0; k < 8; k++) begin
        lat_tab[g][k] = 0;
        pass_tab[g][k] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single select: only testcase 3 runs.
    set_tab(1, 0, 0, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_start(1, 3, 0, 0, 0);
    expect_result(1, 1, 0, 0, 1, REF_DNE);
    pulse_run(1);
    wait_idle(1);

    // Illegal selection: straight to end of run, one failure.
    expect_result(2, 0, 1, 0, 0, REF_CTL);
    pulse_run(2);
    wait_idle(2);

    // All pass; a second run_i mid-run must be ignored.
    set_tab(0, 5, 5, 5, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_start(0, 1, 0, 0, 0);
    expect_start(0, 2, 1, 0, 0);
    expect_start(0, 3, 2, 0, 0);
    expect_start(0, 4, 3, 0, 0);
    expect_result(0, 4, 0, 0, 1, REF_DNE);
    pulse_run(0);
    repeat (8) @(posedge clk);
    pulse_run(0);
    wait_idle(0);

    // Abort while idle does nothing.
    pulse_abort(0);
    repeat (4) @(posedge clk);

    // Testcase 2 never answers: timeout after 10 WAIT cycles.
    set_tab(0, 5, 0, 5, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_start(0, 1, 0, 0, 0);
    expect_start(0, 2, 1, 0, 0);
    expect_start(0, 3, 1, 1, 1);
    expect_start(0, 4, 2, 1, 1);
    expect_result(0, 3, 1, 1, 0, REF_DNE);
    pulse_run(0);
    wait_idle(0);

    // Testcase 2 answers on the exact expiry cycle: counted as a pass.
    set_tab(0, 5, 10, 5, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_start(0, 1, 0, 0, 0);
    expect_start(0, 2, 1, 0, 0);
    expect_start(0, 3, 2, 0, 0);
    expect_start(0, 4, 3, 0, 0);
    expect_result(0, 4, 0, 0, 1, REF_DNE);
    pulse_run(0);
    wait_idle(0);

    // Testcase 1 answers one cycle too late (timeout), testcase 3 reports fail.
    set_tab(0, 11, 5, 5, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_start(0, 1, 0, 0, 0);
    expect_start(0, 2, 0, 1, 1);
    expect_start(0, 3, 1, 1, 1);
    expect_start(0, 4, 1, 2, 1);
    expect_result(0, 2, 2, 1, 0, REF_DNE);
    pulse_run(0);
    wait_idle(0);

    // Abort during WAIT of testcase 2.
    set_tab(0, 5, 0, 5, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_start(0, 1, 0, 0, 0);
    expect_start(0, 2, 1, 0, 0);
    expect_result(0, 1, 0, 0, 0, REF_CTL);
    pulse_run(0);
    wait_tc(0, 2);
    repeat (2) @(posedge clk);
    pulse_abort(0);
    wait_idle(0);

    // Reset in the middle of WAIT of testcase 2: everything clears at once, no done_o.
    set_tab(0, 5, 0, 5, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_start(0, 1, 0, 0, 0);
    expect_start(0, 2, 1, 0, 0);
    pulse_run(0);
    wait_tc(0, 2);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero(0, "mid-run reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("dut%0d leftover starts", g), sq[g].size(), 0);
      check($sformatf("dut%0d leftover results", g), rq[g].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
